// File: rtl/access_lockout_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : access_lockout_if                                               |
// | Brief   : Check request / status bundle for the access lockout block.     |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
interface access_lockout_if;
    logic       i_check;
    logic       i_match;
    logic       i_create;
    logic       o_open;
    logic       o_denied;
    logic       o_locked;
    logic       o_reject;
    logic [1:0] o_fail_cnt;

    modport master (
        output i_check, i_match, i_create,
        input  o_open, o_denied, o_locked, o_reject, o_fail_cnt
    );

    modport slave (
        input  i_check, i_match, i_create,
        output o_open, o_denied, o_locked, o_reject, o_fail_cnt
    );
endinterface
`default_nettype wire

// File: rtl/access_lockout.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : access_lockout                                                  |
// | Brief   : Password check outcome timer with consecutive-failure lockout.  |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module access_lockout #(
    parameter int unsigned OPEN_CYCLES = 500,
    parameter int unsigned DENY_CYCLES = 250,
    parameter int unsigned LOCK_CYCLES = 2000,
    parameter int unsigned MAX_FAILS   = 3
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    access_lockout_if.slave   bus
);

    localparam logic [15:0] c_open_load = 16'(OPEN_CYCLES - 1);
    localparam logic [15:0] c_deny_load = 16'(DENY_CYCLES - 1);
    localparam logic [15:0] c_lock_load = 16'(LOCK_CYCLES - 1);
    localparam logic [2:0]  c_max_fails = 3'(MAX_FAILS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OPEN_S = 2'd1,
        DENY_S = 2'd2,
        LOCK_S = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [1:0]  fail_cnt_q, fail_cnt_d;
    logic        open_q, open_d;
    logic        denied_q, denied_d;
    logic        locked_q, locked_d;
    logic        reject_q, reject_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            timer_q    <= 16'd0;
            fail_cnt_q <= 2'd0;
            open_q     <= 1'b0;
            denied_q   <= 1'b0;
            locked_q   <= 1'b0;
            reject_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            fail_cnt_q <= fail_cnt_d;
            open_q     <= open_d;
            denied_q   <= denied_d;
            locked_q   <= locked_d;
            reject_q   <= reject_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        fail_cnt_d = fail_cnt_q;
        reject_d   = 1'b0;

        case (state_q)
            IDLE: begin
                // Create mode suppresses evaluation entirely, including REJECT.
                if (bus.i_check && !bus.i_create) begin
                    if (bus.i_match) begin
                        state_d    = OPEN_S;
                        timer_d    = c_open_load;
                        fail_cnt_d = 2'd0;
                    end else if (({1'b0, fail_cnt_q} + 3'd1) < c_max_fails) begin
                        state_d    = DENY_S;
                        timer_d    = c_deny_load;
                        fail_cnt_d = fail_cnt_q + 2'd1;
                    end else begin
                        state_d    = LOCK_S;
                        timer_d    = c_lock_load;
                        fail_cnt_d = c_max_fails[1:0];
                    end
                end
            end

            OPEN_S, DENY_S, LOCK_S: begin
                // Busy through the final cycle, so a CHECK there is rejected too.
                reject_d = bus.i_check;
                if (timer_q == 16'd0) begin
                    state_d = IDLE;
                    if (state_q == LOCK_S) begin
                        fail_cnt_d = 2'd0;
                    end
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        open_d   = (state_d == OPEN_S);
        denied_d = (state_d == DENY_S);
        locked_d = (state_d == LOCK_S);
    end

    assign bus.o_open     = open_q;
    assign bus.o_denied   = denied_q;
    assign bus.o_locked   = locked_q;
    assign bus.o_reject   = reject_q;
    assign bus.o_fail_cnt = fail_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_access_lockout.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_access_lockout                                               |
// | Brief   : Directed plus random stimulus against a remaining-time model.   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_access_lockout;

    localparam int OPEN_CYC  = 4;
    localparam int DENY_CYC  = 2;
    localparam int LOCK_CYC  = 8;
    localparam int MAX_FAILS = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    access_lockout_if bus ();

    access_lockout #(
        .OPEN_CYCLES (OPEN_CYC),
        .DENY_CYCLES (DENY_CYC),
        .LOCK_CYCLES (LOCK_CYC),
        .MAX_FAILS   (MAX_FAILS)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fails  = 0;

    // Reference: which display is showing, how many cycles it has left.
    int m_show   = 0;   // 0 none, 1 open, 2 nope, 3 locked
    int m_left   = 0;
    int m_fails  = 0;
    bit m_reject = 1'b0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_show   = 0;
        m_left   = 0;
        m_fails  = 0;
        m_reject = 1'b0;
    endtask

    task automatic model_edge(input bit c, input bit m, input bit cr);
        m_reject = c && (m_left > 0);
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                if (m_show == 3) m_fails = 0;
                m_show = 0;
            end
        end else if (c && !cr) begin
            if (m) begin
                m_show = 1; m_left = OPEN_CYC; m_fails = 0;
            end else if (m_fails + 1 < MAX_FAILS) begin
                m_show = 2; m_left = DENY_CYC; m_fails++;
            end else begin
                m_show = 3; m_left = LOCK_CYC; m_fails = MAX_FAILS;
            end
        end
    endtask

    task automatic compare_all();
        chk("open",     int'(bus.o_open),     int'(m_show == 1));
        chk("denied",   int'(bus.o_denied),   int'(m_show == 2));
        chk("locked",   int'(bus.o_locked),   int'(m_show == 3));
        chk("reject",   int'(bus.o_reject),   int'(m_reject));
        chk("fail_cnt", int'(bus.o_fail_cnt), m_fails);
        chk("onehot",   int'($countones({bus.o_open, bus.o_denied, bus.o_locked}) <= 1), 1);
    endtask

    task automatic cyc(input bit c, input bit m, input bit cr);
        bus.i_check  = c;
        bus.i_match  = m;
        bus.i_create = cr;
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_edge(c, m, cr);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, 1'b0);
    endtask

    // Reset is dropped mid-cycle and checked before any clock edge arrives.
    task automatic async_reset_pulse();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_open",   int'(bus.o_open),     0);
        chk("async_rst_locked", int'(bus.o_locked),   0);
        chk("async_rst_denied", int'(bus.o_denied),   0);
        chk("async_rst_reject", int'(bus.o_reject),   0);
        chk("async_rst_fcnt",   int'(bus.o_fail_cnt), 0);
        model_reset();
        idle(1);
        rst_n = 1'b1;
    endtask

    initial begin
        bus.i_check  = 1'b0;
        bus.i_match  = 1'b0;
        bus.i_create = 1'b0;
        #1;
        chk("reset_open",   int'(bus.o_open),     0);
        chk("reset_denied", int'(bus.o_denied),   0);
        chk("reset_locked", int'(bus.o_locked),   0);
        chk("reset_reject", int'(bus.o_reject),   0);
        chk("reset_fcnt",   int'(bus.o_fail_cnt), 0);
        idle(2);
        rst_n = 1'b1;
        idle(1);

        // Single good entry.
        cyc(1, 1, 0); idle(6);

        // Three failures ending in lockout, then its release.
        cyc(1, 0, 0); idle(3);
        cyc(1, 0, 0); idle(3);
        cyc(1, 0, 0); idle(10);

        // Two failures, a success clears the count, next failure is only a deny.
        cyc(1, 0, 0); idle(3);
        cyc(1, 0, 0); idle(3);
        cyc(1, 1, 0); idle(5);
        cyc(1, 0, 0); idle(3);

        // Into lockout, then CHECK at lock cycle 3 and at its final cycle.
        cyc(1, 0, 0); idle(3);
        cyc(1, 0, 0);
        idle(2);
        cyc(1, 0, 0);
        idle(4);
        cyc(1, 1, 0);
        idle(3);

        // Create mode ignores a failing check.
        cyc(1, 0, 1); idle(2);

        // Reset at lockout cycle 4, then a normal open.
        cyc(1, 0, 0); idle(3);
        cyc(1, 0, 0); idle(3);
        cyc(1, 0, 0);
        idle(3);
        async_reset_pulse();
        cyc(1, 1, 0); idle(6);

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                async_reset_pulse();
            end else begin
                cyc(1'($urandom_range(0, 3) == 0),
                    1'($urandom_range(0, 2) == 0),
                    1'($urandom_range(0, 7) == 0));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/access_lockout.md
ACCESS_LOCKOUT -- requirements
Module: access_lockout

Interface
REQ-001 Parameter OPEN_CYCLES, default 500, SHALL set the number of cycles OPEN is held high after a successful check (legal range 1..65535).
REQ-002 Parameter DENY_CYCLES, default 250, SHALL set the number of cycles DENIED is held high after a failed, non-locking check (legal range 1..65535).
REQ-003 Parameter LOCK_CYCLES, default 2000, SHALL set the number of cycles LOCKED is held high after the final permitted failure (legal range 1..65535).
REQ-004 Parameter MAX_FAILS, default 3, SHALL set the number of consecutive failures that triggers lockout (legal range 1..3).
REQ-005 CLK input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-006 RST_N input, 1 bit: asynchronous, active-low reset.
REQ-007 CHECK input, 1 bit: single-cycle request to evaluate a completed password entry.
REQ-008 MATCH input, 1 bit: result from the comparison stage (1 = entered equals created); it is sampled only in a cycle where CHECK=1.
REQ-009 CREATE input, 1 bit: when 1, the block is in create-password mode and SHALL not evaluate checks.
REQ-010 OPEN output, 1 bit: access granted, for display of OPEN.
REQ-011 DENIED output, 1 bit: most recent check failed, for display of NOPE.
REQ-012 LOCKED output, 1 bit: lockout in progress.
REQ-013 REJECT output, 1 bit: single-cycle pulse, the cycle after a CHECK that was ignored while the block was busy.
REQ-014 FAIL_CNT output, 2 bits: current consecutive-failure count.

Function
REQ-015 The state machine SHALL have exactly four states: IDLE, OPEN_S, DENY_S and LOCK_S; OPEN, DENIED and LOCKED SHALL be registered decodes of OPEN_S, DENY_S and LOCK_S respectively.
REQ-016 The 16-bit down-counter TIMER SHALL decrement once per cycle in OPEN_S, DENY_S and LOCK_S. When it reads 0 in any of these states, the machine SHALL return to IDLE on the next edge.
REQ-017 In IDLE with CHECK=1, CREATE=0 and MATCH=1: go to OPEN_S, load TIMER=OPEN_CYCLES-1 and clear FAIL_CNT to 0.
REQ-018 In IDLE with CHECK=1, CREATE=0, MATCH=0 and FAIL_CNT+1 < MAX_FAILS: go to DENY_S, load TIMER=DENY_CYCLES-1 and increment FAIL_CNT.
REQ-019 In IDLE with CHECK=1, CREATE=0, MATCH=0 and FAIL_CNT+1 >= MAX_FAILS: go to LOCK_S, load TIMER=LOCK_CYCLES-1 and set FAIL_CNT=MAX_FAILS.
REQ-020 Latency: an output SHALL rise on the first edge after the CHECK cycle and SHALL stay high for exactly the parameterised cycle count.
REQ-021 On the LOCK_S to IDLE transition, FAIL_CNT SHALL clear to 0. Exits from OPEN_S and DENY_S SHALL leave FAIL_CNT unchanged.
REQ-022 In IDLE with CHECK=1 and CREATE=1: no state change, no FAIL_CNT change and no REJECT pulse.
REQ-023 CHECK=1 in OPEN_S, DENY_S or LOCK_S SHALL be ignored (no state, TIMER or FAIL_CNT change) and SHALL produce REJECT=1 on the next cycle only.
REQ-024 CHECK arriving on the same edge that a timed state reaches IDLE (TIMER=0) SHALL be treated as busy and rejected.
REQ-025 CREATE toggling in any non-IDLE state SHALL have no effect on the state, TIMER or outputs.
REQ-026 At most one of OPEN, DENIED and LOCKED SHALL be high in any cycle.
REQ-027 FAIL_CNT SHALL never exceed MAX_FAILS and SHALL never wrap.

Reset
REQ-028 RST_N=0 SHALL immediately, independent of CLK, force the state to IDLE and set TIMER=0, FAIL_CNT=0 and OPEN=DENIED=LOCKED=REJECT=0.
REQ-029 Reset asserted mid-lockout or mid-open SHALL abort the timed state. After RST_N rises, the first CHECK SHALL be evaluated normally.

Verification (OPEN_CYCLES=4, DENY_CYCLES=2, LOCK_CYCLES=8, MAX_FAILS=3)
REQ-030 Release reset, CHECK+MATCH=1 once -> OPEN high for exactly 4 cycles starting the next cycle, FAIL_CNT=0, then IDLE.
REQ-031 Three CHECKs with MATCH=0, each after the previous timeout -> DENIED 2 cycles with FAIL_CNT=1, DENIED 2 cycles with FAIL_CNT=2, LOCKED 8 cycles with FAIL_CNT=3, then FAIL_CNT=0.
REQ-032 Two failures, then CHECK+MATCH=1 -> OPEN 4 cycles and FAIL_CNT cleared to 0; a following failure gives DENIED (not LOCKED) with FAIL_CNT=1.
REQ-033 CHECK during LOCKED at cycle 3 and on its final cycle -> REJECT pulses 1 cycle each, LOCKED duration still 8, and the state, TIMER and FAIL_CNT are unaffected by either CHECK.
REQ-034 CHECK with CREATE=1 and MATCH=0 -> no output change and FAIL_CNT stays 0.
REQ-035 RST_N low for 1 cycle at lockout cycle 4 -> all outputs 0 asynchronously; a subsequent CHECK+MATCH=1 opens normally.
